// File: rtl/imm_narrow_pkg.sv
// Shared definitions for the immediate narrowing block: FSM encoding and
// the saturation constants applied to out-of-range values.
package imm_narrow_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;
    localparam logic [15:0] SAT_UNS = 16'hFFFF;

endpackage

// File: rtl/imm_narrow_chk.sv
// Combinational range check of a 32-bit value against a 16-bit signed or
// unsigned range, with optional saturation of out-of-range values.
module narrow_chk
    import imm_narrow_pkg::*;
#(
    parameter bit SAT = 1'b1
) (
    input  logic [31:0] value,
    input  logic        sign_mode,
    output logic [15:0] narrow,
    output logic        ovf
);

    logic fits_signed;
    logic fits_unsigned;

    // Signed fit: bit 15 and everything above it must be copies of one bit.
    assign fits_signed   = (&value[31:15]) | ~(|value[31:15]);
    assign fits_unsigned = ~(|value[31:16]);

    always_comb begin
        ovf    = sign_mode ? ~fits_signed : ~fits_unsigned;
        narrow = value[15:0];
        if (ovf && SAT) begin
            if (!sign_mode)
                narrow = SAT_UNS;
            else if (value[31])
                narrow = SAT_NEG;
            else
                narrow = SAT_POS;
        end
    end

endmodule

// File: rtl/imm_narrow.sv
// Handshaked 32->16 bit immediate narrower: capture, one evaluation cycle,
// then hold the result until the consumer takes it; counts overflows.
module imm_narrow
    import imm_narrow_pkg::*;
#(
    parameter bit SAT   = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Imm_32,
    input  logic             sign_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      Imm_16,
    output logic             ovf,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_cnt
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] imm_q;
    logic        sign_q;
    logic [15:0] imm_16_q;
    logic        ovf_q;
    logic [15:0] chk_val;
    logic        chk_ovf;
    logic        cnt_inc;

    narrow_chk #(.SAT(SAT)) u_chk (
        .value     (imm_q),
        .sign_mode (sign_q),
        .narrow    (chk_val),
        .ovf       (chk_ovf)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = EVAL;
            EVAL:    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign Imm_16    = imm_16_q;
    assign ovf       = ovf_q;
    assign cnt_inc   = (state == EVAL) && chk_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            imm_q    <= '0;
            sign_q   <= 1'b0;
            imm_16_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                imm_q  <= Imm_32;
                sign_q <= sign_mode;
            end
            if (state == EVAL) begin
                imm_16_q <= chk_val;
                ovf_q    <= chk_ovf;
            end
        end
    end

    // A clear coinciding with an overflow still records that overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_cnt <= '0;
        else if (cnt_clr)
            ovf_cnt <= cnt_inc ? CNT_W'(1) : '0;
        else if (cnt_inc && !(&ovf_cnt))
            ovf_cnt <= ovf_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_imm_narrow.sv
// Directed bench for imm_narrow: three instances (saturating, wrapping,
// 2-bit counter) share stimulus and are checked against hand values.
module tb_imm_narrow;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] Imm_32;
    logic        sign_mode;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [15:0] imm_16_a;
    logic [7:0]  ovf_cnt_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [15:0] imm_16_b;
    logic [7:0]  ovf_cnt_b;
    logic        in_ready_c, out_valid_c, ovf_c;
    logic [15:0] imm_16_c;
    logic [1:0]  ovf_cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_narrow #(.SAT(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .Imm_32(Imm_32), .sign_mode(sign_mode), .out_valid(out_valid_a),
        .out_ready(out_ready), .Imm_16(imm_16_a), .ovf(ovf_a),
        .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt_a)
    );

    imm_narrow #(.SAT(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .Imm_32(Imm_32), .sign_mode(sign_mode), .out_valid(out_valid_b),
        .out_ready(out_ready), .Imm_16(imm_16_b), .ovf(ovf_b),
        .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt_b)
    );

    imm_narrow #(.SAT(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .Imm_32(Imm_32), .sign_mode(sign_mode), .out_valid(out_valid_c),
        .out_ready(out_ready), .Imm_16(imm_16_c), .ovf(ovf_c),
        .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; the accept cycle is the one in which
    // in_valid & in_ready is seen, out_valid follows two cycles later.
    task automatic send(input logic [31:0] imm, input logic sm, input logic clr);
        int waited;
        @(negedge clk);
        in_valid  = 1'b1;
        Imm_32    = imm;
        sign_mode = sm;
        waited    = 0;
        while (!in_ready_a && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", 32'(waited < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cnt_clr  = clr;
        check("eval_out_valid", 32'(out_valid_a), 32'd0);
        check("eval_in_ready", 32'(in_ready_a), 32'd0);
        @(negedge clk);
        cnt_clr = 1'b0;
        check("hold_out_valid", 32'(out_valid_a), 32'd1);
        check("hold_out_valid_c", 32'(out_valid_c), 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_valid", 32'(out_valid_a), 32'd0);
        check("idle_in_ready", 32'(in_ready_a), 32'd1);
    endtask

    task automatic expect_res(input string tag, input logic [15:0] ia, input logic oa,
                              input logic [15:0] ib, input logic ob,
                              input logic [7:0] ca, input logic [1:0] cc);
        check({tag, "_imm_a"}, 32'(imm_16_a), 32'(ia));
        check({tag, "_ovf_a"}, 32'(ovf_a), 32'(oa));
        check({tag, "_imm_b"}, 32'(imm_16_b), 32'(ib));
        check({tag, "_ovf_b"}, 32'(ovf_b), 32'(ob));
        check({tag, "_cnt_a"}, 32'(ovf_cnt_a), 32'(ca));
        check({tag, "_cnt_c"}, 32'(ovf_cnt_c), 32'(cc));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        Imm_32    = '0;
        sign_mode = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_imm16", 32'(imm_16_a), 32'h0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_cnt", 32'(ovf_cnt_a), 32'd0);

        send(32'hFFFF_8000, 1'b1, 1'b0);
        expect_res("s_min", 16'h8000, 1'b0, 16'h8000, 1'b0, 8'd0, 2'd0);
        check("s_min_roundtrip", {{16{imm_16_a[15]}}, imm_16_a}, 32'hFFFF_8000);
        take();

        send(32'h0000_8000, 1'b1, 1'b0);
        expect_res("s_pos_ovf", 16'h7FFF, 1'b1, 16'h8000, 1'b1, 8'd1, 2'd1);
        take();

        send(32'h0001_0000, 1'b0, 1'b0);
        expect_res("u_ovf", 16'hFFFF, 1'b1, 16'h0000, 1'b1, 8'd2, 2'd2);
        take();

        send(32'h0000_FFFF, 1'b0, 1'b0);
        expect_res("u_max", 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 8'd2, 2'd2);
        take();

        send(32'h8000_0000, 1'b1, 1'b0);
        expect_res("s_neg_ovf", 16'h8000, 1'b1, 16'h0000, 1'b1, 8'd3, 2'd3);
        take();

        send(32'h1234_5678, 1'b1, 1'b0);
        expect_res("s_big", 16'h7FFF, 1'b1, 16'h5678, 1'b1, 8'd4, 2'd3);
        take();

        send(32'h0000_7FFF, 1'b1, 1'b0);
        expect_res("s_max", 16'h7FFF, 1'b0, 16'h7FFF, 1'b0, 8'd4, 2'd3);
        check("s_max_roundtrip", {{16{imm_16_a[15]}}, imm_16_a}, 32'h0000_7FFF);
        take();

        // Back-pressure: result must hold while new requests are ignored.
        send(32'hFFFF_1234, 1'b1, 1'b0);
        expect_res("stall", 16'h8000, 1'b1, 16'h1234, 1'b1, 8'd5, 2'd3);
        for (int i = 0; i < 5; i++) begin
            in_valid  = i[0] ? 1'b0 : 1'b1;
            Imm_32    = 32'h0000_0042;
            sign_mode = 1'b0;
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid_a), 32'd1);
            check("stall_in_ready", 32'(in_ready_a), 32'd0);
            check("stall_imm", 32'(imm_16_a), 32'h8000);
            check("stall_ovf", 32'(ovf_a), 32'd1);
        end
        in_valid = 1'b0;
        take();
        check("stall_cnt_after", 32'(ovf_cnt_a), 32'd5);

        send(32'hFFFF_FFFF, 1'b0, 1'b1);
        expect_res("clr_inc", 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 8'd1, 2'd1);
        take();

        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_only_a", 32'(ovf_cnt_a), 32'd0);
        check("clr_only_c", 32'(ovf_cnt_c), 32'd0);

        send(32'h0002_0000, 1'b0, 1'b0);
        check("pre_rst_cnt", 32'(ovf_cnt_a), 32'd1);
        take();

        // Reset in the middle of EVAL discards the in-flight result.
        @(negedge clk);
        in_valid  = 1'b1;
        Imm_32    = 32'h0004_0000;
        sign_mode = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_rst_state_eval", 32'(in_ready_a), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_eval_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_eval_cnt", 32'(ovf_cnt_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_eval_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_eval_out_valid2", 32'(out_valid_a), 32'd0);
        check("rst_eval_imm", 32'(imm_16_a), 32'h0);
        check("rst_eval_ovf", 32'(ovf_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
